// File: rtl/delayed_mem_responder.sv
// rtl/delayed_mem_responder.sv - word memory with fixed-latency in-order responses, optional random stall (DELAYED_MEM_RESP_RAND_STALL_EN)
module delayed_mem_responder #(
  parameter int unsigned Depth          = 16384,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [2:0] MaxOut = 3'(MaxOutstanding);

  logic [31:0]            mem_q [Depth];
  logic [AW-1:0]          word_idx;
  logic                   in_range;
  logic                   stall;
  logic [2:0]             out_cnt_q, out_cnt_d;
  logic [2:0]             inflight;
  logic [ReadLatency-1:0] pv_q;
  logic [ReadLatency-1:0] pe_q;
  logic [31:0]            pd_q [ReadLatency];

  assign word_idx = addr_i[AW+1:2];
  assign in_range = (addr_i >> (AW + 2)) == 32'd0;

  // A slot released by the response leaving this cycle can be reused by a grant in
  // the same cycle; this is what allows back-to-back grants at full occupancy.
  assign inflight = out_cnt_q - {2'b00, rvalid_o};
  assign gnt_o    = !rst_i && req_i && (inflight < MaxOut) && !stall;

`ifdef DELAYED_MEM_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  // Fibonacci LFSR (taps 16,14,13,11) free-running out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_seed;

  assign stall       = 1'b0;
  assign unused_seed = ^LfsrSeed;
`endif

  // Outstanding counter next state: +1 per grant, -1 per response
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({gnt_o, rvalid_o})
      2'b10:   out_cnt_d = out_cnt_q + 3'd1;
      2'b01:   out_cnt_d = out_cnt_q - 3'd1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Outstanding counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q <= 3'd0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  // Byte-masked memory write on an in-range write grant; contents are never reset
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: read data captured at the grant edge, shifted ReadLatency stages
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        pd_q[i] <= 32'd0;
      end
    end else begin
      pv_q[0] <= gnt_o;
      pe_q[0] <= gnt_o && !in_range;
      pd_q[0] <= (gnt_o && !we_i && in_range) ? mem_q[word_idx] : 32'd0;
      for (int i = 1; i < ReadLatency; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rvalid_o = pv_q[ReadLatency-1];
  assign err_o    = pe_q[ReadLatency-1];
  assign rdata_o  = pd_q[ReadLatency-1];

endmodule

// File: tb/tb_delayed_mem_responder.sv
// tb/tb_delayed_mem_responder.sv - directed bench for delayed_mem_responder (latency 1/2/3 instances)
module tb_delayed_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b1;
  always #5 clk = ~clk;

  logic        req_a, we_a, gnt_a, rv_a, err_a;
  logic [3:0]  be_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic        req_b, we_b, gnt_b, rv_b, err_b;
  logic [3:0]  be_b;
  logic [31:0] addr_b, wd_b, rd_b;
  logic        req_c, we_c, gnt_c, rv_c, err_c;
  logic [3:0]  be_c;
  logic [31:0] addr_c, wd_c, rd_c;

  delayed_mem_responder #(.ReadLatency(1), .MaxOutstanding(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a), .we_i(we_a),
    .be_i(be_a), .wdata_i(wd_a), .rvalid_o(rv_a), .rdata_o(rd_a), .err_o(err_a));

  delayed_mem_responder #(.Depth(256), .ReadLatency(3), .MaxOutstanding(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b), .we_i(we_b),
    .be_i(be_b), .wdata_i(wd_b), .rvalid_o(rv_b), .rdata_o(rd_b), .err_o(err_b));

  delayed_mem_responder #(.Depth(256), .ReadLatency(2), .MaxOutstanding(2)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr_c), .we_i(we_c),
    .be_i(be_c), .wdata_i(wd_c), .rvalid_o(rv_c), .rdata_o(rd_c), .err_o(err_c));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_gnt;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t tv [15];

`ifdef DELAYED_MEM_RESP_RAND_STALL_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, mo;
    logic eg;
    logic exp_g [16];

    //              req we be     addr          wdata         gnt rv rdata         err
    tv[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b0};
    tv[1]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
    tv[2]  = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 4'h2, 32'h0000_0100, 32'h0000_AB00, 1'b1, 1'b0, 32'h0,         1'b0};
    tv[4]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
    tv[5]  = '{1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0,         1'b1, 1'b1, 32'hDEAD_ABEF, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0107, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         1'b1};
    tv[7]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0106, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
    tv[8]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0104, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
    tv[10] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0};
    tv[11] = '{1'b1, 1'b1, 4'hF, 32'hFFFF_0100, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
    tv[12] = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1};
    tv[13] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hDEAD_ABEF, 1'b0};
    tv[14] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0};

    req_a = 1'b1; we_a = 1'b0; be_a = 4'h0; addr_a = 32'h0; wd_a = 32'h0;
    req_b = 1'b1; we_b = 1'b0; be_b = 4'h0; addr_b = 32'h0; wd_b = 32'h0;
    req_c = 1'b1; we_c = 1'b0; be_c = 4'h0; addr_c = 32'h0; wd_c = 32'h0;

    // reset state: no grant even with req high, outputs idle
    repeat (2) @(negedge clk);
    chk("reset_gnt_a", gnt_a, 1'b0);
    chk("reset_rvalid_a", rv_a, 1'b0);
    chk("reset_rdata_a", rd_a, 32'h0);
    chk("reset_err_a", err_a, 1'b0);
    chk("reset_gnt_c", gnt_c, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; rst_c = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;

`ifdef DELAYED_MEM_RESP_RAND_STALL_EN
    begin
      int ng, nr, nstall;
      logic prev_g;
      ng = 0; nr = 0; nstall = 0; prev_g = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        @(posedge clk); #1;
        req_a = 1'b1; we_a = 1'b1; be_a = 4'hF; addr_a = 32'h40; wd_a = k;
        @(negedge clk);
        eg = (m_lfsr[1:0] != 2'b00);
        chk($sformatf("stall_gnt[%0d]", k), gnt_a, eg);
        chk($sformatf("stall_rvalid[%0d]", k), rv_a, prev_g);
        if (gnt_a) ng++;
        else nstall++;
        if (rv_a) nr++;
        prev_g = gnt_a;
      end
      @(posedge clk); #1;
      req_a = 1'b0;
      @(negedge clk);
      if (rv_a) nr++;
      @(posedge clk); #1;
      @(negedge clk);
      if (rv_a) nr++;
      chk("stall_resp_count", nr, ng);
      chk("stall_fraction_nonzero", (nstall > 100 && nstall < 400), 1'b1);
    end
`else
    // table-driven directed vectors on the latency-1 instance
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      req_a = tv[i].req; we_a = tv[i].we; be_a = tv[i].be;
      addr_a = tv[i].addr; wd_a = tv[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), gnt_a, tv[i].e_gnt);
      chk($sformatf("v%0d_rvalid", i), rv_a, tv[i].e_rv);
      chk($sformatf("v%0d_rdata", i), rd_a, tv[i].e_rd);
      chk($sformatf("v%0d_err", i), err_a, tv[i].e_err);
    end

    // latency 3, two outstanding: preload six words, then six back-to-back reads
    g = 0;
    for (int k = 0; k < 40 && g < 6; k++) begin
      @(posedge clk); #1;
      req_b = 1'b1; we_b = 1'b1; be_b = 4'hF; addr_b = g * 4; wd_b = 32'hA0 + g;
      @(negedge clk);
      if (gnt_b) g++;
    end
    chk("preload_grants", g, 6);
    @(posedge clk); #1;
    req_b = 1'b0; we_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    g = 0; r = 0; mo = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      req_b = (g < 6); we_b = 1'b0; addr_b = g * 4;
      @(negedge clk);
      eg = (g < 6) && (k % 3 != 2);
      exp_g[k] = eg;
      chk($sformatf("lat3_gnt[%0d]", k), gnt_b, eg);
      chk($sformatf("lat3_rvalid[%0d]", k), rv_b, (k >= 3) ? exp_g[k-3] : 1'b0);
      if (rv_b) begin
        chk($sformatf("lat3_rdata[%0d]", r), rd_b, 32'hA0 + r);
        chk($sformatf("lat3_err[%0d]", r), err_b, 1'b0);
        r++;
      end
      mo = mo + (gnt_b ? 1 : 0) - (rv_b ? 1 : 0);
      chk($sformatf("lat3_outstanding_le2[%0d]", k), (mo <= 2), 1'b1);
      if (gnt_b) g++;
    end
    chk("lat3_resp_count", r, 6);

    // latency 2: reset one cycle after a grant discards the in-flight response
    @(posedge clk); #1;
    req_c = 1'b1; we_c = 1'b0; addr_c = 32'h0;
    @(negedge clk);
    chk("rst_pre_gnt", gnt_c, 1'b1);
    @(posedge clk); #1;
    rst_c = 1'b1;
    @(negedge clk);
    chk("rst_during_gnt", gnt_c, 1'b0);
    chk("rst_during_rvalid", rv_c, 1'b0);
    @(posedge clk); #1;
    rst_c = 1'b0; req_c = 1'b1; we_c = 1'b1; be_c = 4'hF; addr_c = 32'h8; wd_c = 32'h5;
    @(negedge clk);
    chk("rst_post_gnt", gnt_c, 1'b1);
    chk("rst_post_rvalid", rv_c, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      req_c = 1'b0;
      @(negedge clk);
      chk($sformatf("rst_after_rvalid[%0d]", j), rv_c, (j == 1));
      chk($sformatf("rst_after_rdata[%0d]", j), rd_c, 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delayed_mem_responder.md
DELAYED_MEM_RESPONDER -- requirements
Module: delayed_mem_responder

Interface
REQ-001 SHALL have parameter Depth, default 16384, memory size in 32-bit words, power of 2.
REQ-002 SHALL have parameter ReadLatency, default 1, grant-to-rvalid cycles, legal range 1..4.
REQ-003 SHALL have parameter MaxOutstanding, default 2, maximum granted-but-unanswered requests, range 1..4.
REQ-004 SHALL have parameter LfsrSeed, default 16'hACE1, stall LFSR reset value, nonzero.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_i  input  1  host request.
REQ-008 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-009 SHALL have port addr_i  input  32  byte address.
REQ-010 SHALL have port we_i  input  1  write (1) / read (0).
REQ-011 SHALL have port be_i  input  4  byte enables.
REQ-012 SHALL have port wdata_i  input  32  write data.
REQ-013 SHALL have port rvalid_o  output  1  response valid.
REQ-014 SHALL have port rdata_o  output  32  read data.
REQ-015 SHALL have port err_o  output  1  response error, qualified by rvalid_o.

Function
REQ-016 SHALL define AW = clog2(Depth); request in range iff addr_i[31:AW+2] == 0; addr_i[1:0] ignored.
REQ-017 SHALL drive gnt_o = req_i && (outstanding < MaxOutstanding) && !stall, combinationally.
REQ-018 SHALL, on grant of an in-range write, update only bytes with be_i set, at word addr_i[AW+1:2], on that clock edge.
REQ-019 SHALL, on grant of an in-range read, capture the word at grant edge (write-before-read order across cycles).
REQ-020 SHALL, on grant of an out-of-range request, perform no memory access and return err_o=1, rdata_o=0.
REQ-021 SHALL return exactly one response per grant, reads and writes alike, exactly ReadLatency cycles after the grant cycle, in grant order.
REQ-022 SHALL hold rdata_o=0 for write responses and whenever rvalid_o=0; err_o=0 whenever rvalid_o=0.
REQ-023 SHALL keep a 3-bit outstanding counter: +1 on grant, -1 on rvalid_o, unchanged when both occur in the same cycle.
REQ-024 SHALL sustain one grant per cycle when MaxOutstanding >= ReadLatency and no stall.
REQ-025 SHALL ignore addr_i/we_i/be_i/wdata_i in cycles without a grant; req_i with gnt_o=0 has no side effect.

Reset
REQ-026 SHALL, while rst_i=1, force gnt_o-path state idle: outstanding=0, all response pipeline stages invalid, LFSR=LfsrSeed.
REQ-027 SHALL reset outputs to rvalid_o=0, rdata_o=0, err_o=0; gnt_o=0 while rst_i=1.
REQ-028 SHALL discard responses in flight at reset assertion; none appear after release.
REQ-029 SHALL leave memory contents unreset.

Configuration
REQ-030 SHALL, with macro DELAYED_MEM_RESP_RAND_STALL_EN defined, include a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle out of reset, with stall = (lfsr[1:0] == 2'b00).
REQ-031 SHALL, without DELAYED_MEM_RESP_RAND_STALL_EN, tie stall=0 and omit the LFSR; LfsrSeed unused.

Verification
REQ-032 SHALL cover: macro off, ReadLatency=1; write 0xDEADBEEF be=4'hF to 0x100, then read 0x100 -> gnt same cycle each, rvalid one cycle after each grant, read rdata=0xDEADBEEF, err=0.
REQ-033 SHALL cover: partial write be=4'b0010 wdata=0x0000AB00 to 0x100 after REQ-032 -> read returns 0xDEADABEF.
REQ-034 SHALL cover: read 0x0001_0000 with Depth=16384 -> rvalid with err=1, rdata=0; following in-range access unaffected.
REQ-035 SHALL cover: ReadLatency=3, MaxOutstanding=2, req_i held high for 6 reads -> gnt pattern 1,1,0,1,1,0..., never more than 2 outstanding, responses in order.
REQ-036 SHALL cover: rst_i asserted one cycle after a grant with ReadLatency=2 -> no rvalid after release; first post-reset grant available immediately.
REQ-037 SHALL cover: macro on, req_i held high 1000 cycles -> gnt_o low exactly in cycles where lfsr[1:0]==0 (approx. 25%), response count equals grant count.
